// File: rtl/hls_srl_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// hls_srl_fifo_ctrl
//
// First-word-fall-through FIFO for HLS dataflow channels. It is built from a
// DEPTH-entry shift-register store plus the occupancy, read-index and flag
// logic. Writes shift in at index 0. The read side presents the oldest entry,
// which sits at index addr.
//
// Optional feature: define HLS_SRL_FIFO_ERR_EN to build sticky detection of
// requests made against a full or empty FIFO. When it is undefined, err is
// tied to 0.
//
// Ports:
//   clk         rising-edge clock for all logic
//   reset       synchronous, active-high
//   if_write_ce write-side clock enable
//   if_write    write request
//   if_din      write data
//   if_full_n   1 = space available (registered)
//   if_read_ce  read-side clock enable
//   if_read     read request; consumes if_dout
//   if_dout     oldest entry; valid while if_empty_n = 1
//   if_empty_n  1 = data available (registered)
//   err         sticky protocol-violation flag
//
// Handshake: a word moves on the write side in any cycle where
// if_write & if_write_ce & if_full_n is high at the rising edge. A word is
// consumed on the read side in any cycle where if_read & if_read_ce &
// if_empty_n is high at the rising edge. A request made while the matching
// flag is low is ignored.
// ---------------------------------------------------------------------------
module hls_srl_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  err
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_NONEMPTY = 2'd1,
    ST_FULL     = 2'd2
  } state_t;

  // Debug view of the FSM, for checkers bound to this module.
  typedef struct packed {
    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr;
  } dbg_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  push;
  logic                  pop;
  dbg_t                  dbg;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read  & if_read_ce  & if_empty_n;
  assign dbg  = '{state: state, cnt: cnt, addr: addr};

  // The store is not reset, because its contents are don't-care while empty.
  // A push in the reset cycle is discarded, so it also does not shift.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= if_din;
    end
  end

  assign if_dout = mem[addr];

  // Occupancy FSM. addr follows cnt-1 and is held at 0 while empty. The
  // flags are decoded from the next state, so they change one edge after
  // the push or pop that caused them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      cnt        <= '0;
      addr       <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state      <= ST_NONEMPTY;
            cnt        <= CNT_W'(1);
            addr       <= '0;
            if_empty_n <= 1'b1;
            if_full_n  <= 1'b1;
          end
        end
        ST_NONEMPTY: begin
          if (push && !pop) begin
            cnt  <= cnt + 1'b1;
            addr <= addr + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= ST_FULL;
              if_full_n <= 1'b0;
            end
          end else if (pop && !push) begin
            if (cnt == CNT_W'(1)) begin
              state      <= ST_EMPTY;
              cnt        <= '0;
              addr       <= '0;
              if_empty_n <= 1'b0;
            end else begin
              cnt  <= cnt - 1'b1;
              addr <= addr - 1'b1;
            end
          end
          // Push and pop together leave cnt and addr where they are.
        end
        ST_FULL: begin
          if (pop) begin
            state     <= ST_NONEMPTY;
            cnt       <= cnt - 1'b1;
            addr      <= addr - 1'b1;
            if_full_n <= 1'b1;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          cnt        <= '0;
          addr       <= '0;
          if_empty_n <= 1'b0;
          if_full_n  <= 1'b1;
        end
      endcase
    end
  end

`ifdef HLS_SRL_FIFO_ERR_EN
  logic err_q;

  // Sticky flag: it is set by any request made against the wrong flag, and
  // only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((if_write & if_write_ce & ~if_full_n) |
                 (if_read & if_read_ce & ~if_empty_n)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hls_srl_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hls_srl_fifo_ctrl
//
// Directed testbench with two instances. u4 has DEPTH=4 and DATA_WIDTH=8.
// u2 has DEPTH=2 and DATA_WIDTH=8. Inputs change 1 time unit after each
// rising edge. Outputs are sampled at that same point, before new inputs
// are applied.
// ---------------------------------------------------------------------------
module tb_hls_srl_fifo_ctrl;

  logic clk;
  int   checks;
  int   errors;

`ifdef HLS_SRL_FIFO_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // DEPTH=4 instance signals.
  logic       rst4, wce4, w4, rce4, r4, full_n4, empty_n4, err4;
  logic [7:0] din4, dout4;
  // DEPTH=2 instance signals.
  logic       rst2, wce2, w2, rce2, r2, full_n2, empty_n2, err2;
  logic [7:0] din2, dout2;

  hls_srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u4 (
    .clk(clk), .reset(rst4),
    .if_write_ce(wce4), .if_write(w4), .if_din(din4), .if_full_n(full_n4),
    .if_read_ce(rce4), .if_read(r4), .if_dout(dout4), .if_empty_n(empty_n4),
    .err(err4)
  );

  hls_srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) u2 (
    .clk(clk), .reset(rst2),
    .if_write_ce(wce2), .if_write(w2), .if_din(din2), .if_full_n(full_n2),
    .if_read_ce(rce2), .if_read(r2), .if_dout(dout2), .if_empty_n(empty_n2),
    .err(err2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input logic w, input logic [7:0] d, input logic r);
    w4 = w; din4 = d; r4 = r;
    tick();
    w4 = 1'b0; r4 = 1'b0;
  endtask

  task automatic reset4(input logic w, input logic [7:0] d);
    rst4 = 1'b1; w4 = w; din4 = d;
    tick();
    rst4 = 1'b0; w4 = 1'b0;
  endtask

  // Directed steps
  initial begin
    checks = 0; errors = 0;
    rst4 = 1'b1; wce4 = 1'b1; w4 = 1'b0; din4 = '0; rce4 = 1'b1; r4 = 1'b0;
    rst2 = 1'b1; wce2 = 1'b1; w2 = 1'b0; din2 = '0; rce2 = 1'b1; r2 = 1'b0;
    tick(); tick();
    rst4 = 1'b0; rst2 = 1'b0;

    // Reset state
    check("rst_empty_n", empty_n4, 1'b0);
    check("rst_full_n",  full_n4,  1'b1);
    check("rst_err",     err4,     1'b0);
    check("rst2_empty_n", empty_n2, 1'b0);

    // Fill to full
    cyc4(1, 8'h11, 0);
    check("fill1_empty_n", empty_n4, 1'b1);
    check("fill1_dout",    dout4,    8'h11);
    check("fill1_full_n",  full_n4,  1'b1);
    cyc4(1, 8'h22, 0);
    check("fill2_dout",    dout4,    8'h11);
    cyc4(1, 8'h33, 0);
    check("fill3_full_n",  full_n4,  1'b1);
    cyc4(1, 8'h44, 0);
    check("fill4_full_n",  full_n4,  1'b0);
    check("fill4_dout",    dout4,    8'h11);

    // Write while full is ignored
    cyc4(1, 8'h55, 0);
    check("wfull_full_n", full_n4, 1'b0);
    check("wfull_dout",   dout4,   8'h11);
    check("wfull_err",    err4,    EXP_ERR);

    // Drain in order
    cyc4(0, 8'h00, 1);
    check("pop1_dout",   dout4,   8'h22);
    check("pop1_full_n", full_n4, 1'b1);
    cyc4(0, 8'h00, 1);
    check("pop2_dout",   dout4,   8'h33);
    cyc4(0, 8'h00, 1);
    check("pop3_dout",   dout4,   8'h44);
    check("pop3_empty_n", empty_n4, 1'b1);
    cyc4(0, 8'h00, 1);
    check("pop4_empty_n", empty_n4, 1'b0);
    check("pop4_full_n",  full_n4,  1'b1);

    // Read while empty is ignored; err stays set until reset
    cyc4(0, 8'h00, 1);
    check("rempty_empty_n", empty_n4, 1'b0);
    check("rempty_full_n",  full_n4,  1'b1);
    check("rempty_err",     err4,     EXP_ERR);
    reset4(0, 8'h00);
    check("errclr_err", err4, 1'b0);

    // Simultaneous push and pop while holding 2 entries
    cyc4(1, 8'hA0, 0);
    cyc4(1, 8'hA1, 0);
    check("pp0_dout", dout4, 8'hA0);
    cyc4(1, 8'hA2, 1);
    check("pp1_dout",    dout4,    8'hA1);
    check("pp1_empty_n", empty_n4, 1'b1);
    check("pp1_full_n",  full_n4,  1'b1);
    cyc4(1, 8'hA3, 1);
    check("pp2_dout", dout4, 8'hA2);
    cyc4(1, 8'hA4, 1);
    check("pp3_dout",    dout4,    8'hA3);
    check("pp3_full_n",  full_n4,  1'b1);
    // Two entries must remain: A3 then A4
    cyc4(0, 8'h00, 1);
    check("ppd1_dout",    dout4,    8'hA4);
    check("ppd1_empty_n", empty_n4, 1'b1);
    cyc4(0, 8'h00, 1);
    check("ppd2_empty_n", empty_n4, 1'b0);

    // A read with read_ce=0 is frozen
    cyc4(1, 8'h5A, 0);
    rce4 = 1'b0;
    cyc4(0, 8'h00, 1);
    check("rce0_empty_n", empty_n4, 1'b1);
    check("rce0_dout",    dout4,    8'h5A);
    rce4 = 1'b1;
    cyc4(0, 8'h00, 1);
    check("rce1_empty_n", empty_n4, 1'b0);

    // Reset mid-transfer with a simultaneous push
    cyc4(1, 8'h01, 0);
    cyc4(1, 8'h02, 0);
    cyc4(1, 8'h03, 0);
    reset4(1, 8'h99);
    check("mrst_empty_n", empty_n4, 1'b0);
    check("mrst_full_n",  full_n4,  1'b1);
    check("mrst_err",     err4,     1'b0);
    cyc4(1, 8'h77, 0);
    check("post_empty_n", empty_n4, 1'b1);
    check("post_dout",    dout4,    8'h77);
    cyc4(0, 8'h00, 1);
    check("post_pop_empty_n", empty_n4, 1'b0);

    // DEPTH=2: write held with ce low for 5 cycles, then ce raised
    w2 = 1'b1; wce2 = 1'b0; din2 = 8'hC1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("d2_ce0_empty_n", empty_n2, 1'b0);
      check("d2_ce0_full_n",  full_n2,  1'b1);
    end
    wce2 = 1'b1;
    tick();
    check("d2_p1_empty_n", empty_n2, 1'b1);
    check("d2_p1_full_n",  full_n2,  1'b1);
    check("d2_p1_dout",    dout2,    8'hC1);
    din2 = 8'hC2;
    tick();
    check("d2_p2_full_n", full_n2, 1'b0);
    check("d2_p2_dout",   dout2,   8'hC1);
    din2 = 8'hC3;
    tick();
    w2 = 1'b0;
    check("d2_wfull_full_n", full_n2, 1'b0);
    check("d2_wfull_err",    err2,    EXP_ERR);
    r2 = 1'b1;
    tick();
    check("d2_pop1_dout",   dout2,   8'hC2);
    check("d2_pop1_full_n", full_n2, 1'b1);
    tick();
    r2 = 1'b0;
    check("d2_pop2_empty_n", empty_n2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hls_srl_fifo_ctrl.md
Name: hls_srl_fifo_ctrl

Overview:
Complete first-word-fall-through FIFO for HLS dataflow start/data channels. It wraps a DEPTH-entry shift-register store with the pointer, occupancy and handshake logic that both producer and consumer see. The write side shifts data in at index 0, and the read side presents the oldest entry at index addr. It sits between a producer process (ap_fifo write interface) and a consumer process (ap_fifo read interface) inside a dataflow region.

Parameters:
DATA_WIDTH, 1, payload width in bits
ADDR_WIDTH, 1, index width; must equal clog2(DEPTH)
DEPTH, 2, number of entries; must be >= 2

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
if_write_ce  in  1  write clock-enable
if_write  in  1  write request
if_din  in  DATA_WIDTH  write data
if_full_n  out  1  1 = space available
if_read_ce  in  1  read clock-enable
if_read  in  1  read request (consumes if_dout)
if_dout  out  DATA_WIDTH  oldest entry, valid while if_empty_n=1
if_empty_n  out  1  1 = data available
err  out  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n. A request made against full or empty is ignored and changes no state.
- Storage: on push, entries shift (mem[i+1] <= mem[i]) and mem[0] <= if_din. No shift on pop alone.
- if_dout = mem[addr], combinational from registered addr and array. Contents are don't-care while if_empty_n=0.
- State machine over the occupancy count cnt (0..DEPTH) has three states:
  - EMPTY (cnt=0): push goes to NONEMPTY (or FULL if DEPTH=1, which is disallowed); pop is impossible.
  - NONEMPTY (0<cnt<DEPTH): push only gives cnt+1, addr+1, and goes to FULL when cnt+1=DEPTH. Pop only gives cnt-1, addr-1, and goes to EMPTY when cnt=1, with addr held at 0. Push and pop together leave cnt and addr unchanged.
  - FULL (cnt=DEPTH): push is impossible; pop gives cnt-1, addr-1 and goes to NONEMPTY.
- addr tracks cnt-1, saturating at 0 when empty. It never wraps and never exceeds DEPTH-1.
- if_full_n and if_empty_n are registered and decoded from the next state. Effect is visible the cycle after the push/pop edge.
- Latency: a word pushed at edge N appears on if_dout with if_empty_n=1 after edge N when the FIFO was empty (1 cycle). Ordering is strict FIFO.
- Simultaneous push+pop in NONEMPTY: the new word enters at index 0, the oldest is consumed, and the next-oldest lands at addr.
- Reset (any cycle, including mid-transfer) on the next edge: cnt=0, addr=0, state=EMPTY, if_empty_n=0, if_full_n=1, err=0. Array contents are not reset. push/pop in the reset cycle are discarded.
- if_write_ce=0 or if_read_ce=0 freezes that side entirely.

Optional Feature:
Macro HLS_SRL_FIFO_ERR_EN.
- Defined: err sets on any edge where (if_write & if_write_ce & ~if_full_n) or (if_read & if_read_ce & ~if_empty_n). It stays set until reset and never changes FIFO state.
- Undefined: err is tied to 0 and no detection logic is built.

Test Plan:
1. DEPTH=4, DATA_WIDTH=8. Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles -> if_full_n=0 after 4th edge, if_empty_n=1 after 1st edge, if_dout=0x11 throughout.
2. From full, pop 4 times -> if_dout sequence 0x11,0x22,0x33,0x44; if_empty_n=0 and if_full_n=1 after 4th edge.
3. DEPTH=4 holding 2 entries (0xA0,0xA1), push 0xA2 and pop on the same edge for 3 cycles with pushes 0xA2,0xA3,0xA4 -> dout 0xA0,0xA1,0xA2,0xA3; cnt stays 2, flags unchanged.
4. Write while full (0x55) and read while empty -> state and data unchanged. With HLS_SRL_FIFO_ERR_EN, err=1 from the next edge until reset; without it, err=0.
5. Push 3 words, assert reset for 1 cycle with a simultaneous push -> if_empty_n=0, if_full_n=1, err=0 next cycle. A subsequent push of 0x77 appears on if_dout one cycle later.
6. DEPTH=2, hold if_write=1 with if_write_ce=0 for 5 cycles -> no state change; raise ce -> 2 pushes, then if_full_n=0.
